// File: rtl/black_pawn_push_serializer.sv
// Serialises a black pawn push-target bitboard into one move per valid/ready
// handshake. Targets are emitted in ascending square order, and a promotion target expands to Q,R,B,N.
module black_pawn_push_serializer #(
  parameter bit PROMO_EXPAND = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] push_bb,
  input  logic [63:0] black_pawn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic [2:0]  move_promo,
  output logic        move_dbl,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  move_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic [63:0] push_r;
  logic [63:0] pawn_r;

  logic [5:0]  tgt_s;
  logic        any_s;
  logic [5:0]  single_idx_s;
  logic [5:0]  double_idx_s;
  logic        single_ok_s;
  logic        double_ok_s;
  logic        promo_tgt_s;
  logic        promo_more_s;

  // Priority encoder: lowest set bit of the latched target board.
  always_comb begin
    tgt_s = 6'd0;
    any_s = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      tgt_s = push_r[i] ? 6'(i) : tgt_s;
      any_s = any_s | push_r[i];
    end
  end

  // Origin lookup for the current target; index sums wrap above 63 but are range-gated.
  always_comb begin
    single_idx_s = tgt_s + 6'd8;
    double_idx_s = tgt_s + 6'd16;
    single_ok_s  = (tgt_s < 6'd56) && pawn_r[single_idx_s];
    double_ok_s  = (tgt_s >= 6'd32) && (tgt_s <= 6'd39) && pawn_r[double_idx_s];
    promo_tgt_s  = (tgt_s < 6'd8);
    promo_more_s = PROMO_EXPAND && (move_promo != 3'd0) && (move_promo < 3'd4);
  end

  // Control FSM; all move fields and status flags are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      push_r     <= 64'd0;
      pawn_r     <= 64'd0;
      out_valid  <= 1'b0;
      move_from  <= 6'd0;
      move_to    <= 6'd0;
      move_promo <= 3'd0;
      move_dbl   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      move_count <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            push_r     <= push_bb;
            pawn_r     <= black_pawn;
            err        <= 1'b0;
            move_count <= 6'd0;
            busy       <= 1'b1;
            state_r    <= SCAN;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          if (!any_s) begin
            done    <= 1'b1;
            state_r <= DONE;
          end else if (single_ok_s) begin
            move_from  <= single_idx_s;
            move_to    <= tgt_s;
            move_dbl   <= 1'b0;
            move_promo <= promo_tgt_s ? 3'd1 : 3'd0;
            out_valid  <= 1'b1;
            state_r    <= EMIT;
          end else if (double_ok_s) begin
            move_from  <= double_idx_s;
            move_to    <= tgt_s;
            move_dbl   <= 1'b1;
            move_promo <= 3'd0;
            out_valid  <= 1'b1;
            state_r    <= EMIT;
          end else begin
            // Orphan target: drop it, flag it, and rescan next cycle.
            push_r[tgt_s] <= 1'b0;
            err           <= 1'b1;
            state_r       <= SCAN;
          end
        end
        EMIT: begin
          if (out_ready) begin
            move_count <= move_count + 6'd1;
            if (promo_more_s) begin
              move_promo <= move_promo + 3'd1;
              state_r    <= EMIT;
            end else begin
              push_r[move_to] <= 1'b0;
              move_promo      <= 3'd0;
              out_valid       <= 1'b0;
              state_r         <= SCAN;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
